// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write-side framer.
// Data width, header layout and the framer state encoding.
package fifo_pkg;

    localparam int         FIFO_DW   = 8;
    localparam logic [3:0] HDR_SOF   = 4'hA;
    localparam int         HDR_LEN_W = 4;

    typedef enum logic [1:0] {
        COLLECT,
        HDR,
        PAY,
        DROP
    } state_t;

endpackage

// File: rtl/async_fifo_wr_framer_if.sv
// Source stream and FIFO write port bundle for the framer.
// The slave modport is the framer's view; master is the environment's.
interface async_fifo_wr_framer_if;
    import fifo_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [FIFO_DW-1:0] s_data;
    logic               s_last;
    logic               fifo_full;
    logic               fifo_w_en;
    logic [FIFO_DW-1:0] fifo_wdata;

    modport master (
        output s_valid, s_data, s_last, fifo_full,
        input  s_ready, fifo_w_en, fifo_wdata
    );

    modport slave (
        input  s_valid, s_data, s_last, fifo_full,
        output s_ready, fifo_w_en, fifo_wdata
    );

endinterface

// File: rtl/frame_buf.sv
// Payload register file: one synchronous write port and
// one combinational read port.
module frame_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [FIFO_DW-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [FIFO_DW-1:0] rdata
);

    logic [FIFO_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/async_fifo_wr_framer.sv
// Write-side packet framer: buffers one packet, then emits a
// {SOF,len} header and the payload into the async FIFO.
module async_fifo_wr_framer
    import fifo_pkg::*;
#(
    parameter int         MAX_LEN = 15,
    parameter logic [3:0] SOF     = HDR_SOF
) (
    input  logic                   w_clk,
    input  logic                   rst_n,
    async_fifo_wr_framer_if.slave  bus,
    output logic                   busy,
    output logic                   drop_pulse,
    output logic [7:0]             pkt_cnt
);

    localparam int LW = HDR_LEN_W;

    state_t             state;
    state_t             state_d;
    logic [LW-1:0]      cnt;
    logic [LW-1:0]      len;
    logic [LW-1:0]      idx;
    logic [LW:0]        cnt_inc;
    logic               drop_q;
    logic [7:0]         pkt_q;
    logic               rdy;
    logic               wr_ok;
    logic               beat;
    logic               accept;
    logic               fits;
    logic               at_limit;
    logic               last_pay;
    logic [FIFO_DW-1:0] rd_data;

    // Outputs are forced to reset values while rst_n is low,
    // since the state register only clears on the clock edge.
    assign rdy   = rst_n && (state == COLLECT || state == DROP);
    assign wr_ok = rst_n && (state == HDR || state == PAY);

    assign beat     = bus.s_valid && rdy;
    assign accept   = wr_ok && !bus.fifo_full;
    assign cnt_inc  = {1'b0, cnt} + (LW+1)'(1);
    assign fits     = cnt_inc <= (LW+1)'(MAX_LEN);
    assign at_limit = cnt == LW'(MAX_LEN - 1);
    assign last_pay = idx == (len - LW'(1));

    assign bus.s_ready   = rdy;
    assign bus.fifo_w_en = accept;
    assign busy          = wr_ok;
    assign drop_pulse    = drop_q;
    assign pkt_cnt       = pkt_q;

    frame_buf #(
        .DEPTH (16),
        .AW    (LW)
    ) u_buf (
        .clk   (w_clk),
        .we    (state == COLLECT && beat),
        .waddr (cnt),
        .wdata (bus.s_data),
        .raddr (idx),
        .rdata (rd_data)
    );

    always_ff @(posedge w_clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d        = state;
        bus.fifo_wdata = '0;
        if (rst_n) begin
            unique case (state)
                COLLECT: begin
                    if (beat) begin
                        if (bus.s_last && fits) begin
                            state_d = HDR;
                        end else if (!bus.s_last && at_limit) begin
                            state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    if (beat && bus.s_last) begin
                        state_d = COLLECT;
                    end
                end
                HDR: begin
                    bus.fifo_wdata = {SOF, len};
                    if (accept) begin
                        state_d = PAY;
                    end
                end
                PAY: begin
                    bus.fifo_wdata = rd_data;
                    if (accept && last_pay) begin
                        state_d = COLLECT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            len    <= '0;
            idx    <= '0;
            drop_q <= 1'b0;
            pkt_q  <= '0;
        end else begin
            drop_q <= (state == DROP) && beat && bus.s_last;
            if (state == COLLECT && beat) begin
                if (bus.s_last && fits) begin
                    len <= cnt_inc[LW-1:0];
                    cnt <= '0;
                end else if (at_limit) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_inc[LW-1:0];
                end
            end
            if (state == HDR && accept) begin
                idx <= '0;
            end
            if (state == PAY && accept) begin
                if (last_pay) begin
                    pkt_q <= pkt_q + 8'd1;
                end else begin
                    idx <= idx + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_framer.sv
// Scoreboard bench for async_fifo_wr_framer: expected FIFO bytes
// are queued when a packet is sent and popped on each FIFO write.
module tb_async_fifo_wr_framer;

    logic       w_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic       drop_pulse;
    logic [7:0] pkt_cnt;

    async_fifo_wr_framer_if bus ();

    async_fifo_wr_framer dut (
        .w_clk      (w_clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .busy       (busy),
        .drop_pulse (drop_pulse),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 w_clk = ~w_clk;

    int         pass_cnt    = 0;
    int         total_cnt   = 0;
    int         cyc         = 0;
    int         beat_cyc    = 0;
    int         ready_waits = 0;
    int         wen_count   = 0;
    int         drop_count  = 0;
    int         drop_cyc    = 0;
    logic [7:0] sb[$];
    int         wr_cyc[$];

    always @(posedge w_clk) cyc <= cyc + 1;

    always @(negedge w_clk) begin
        logic [7:0] exp_b;
        if (bus.fifo_w_en) begin
            wen_count++;
            wr_cyc.push_back(cyc);
            total_cnt++;
            if (bus.fifo_full) begin
                $display("FAIL w_en_while_full: w_en=1 full=1, required w_en=0");
            end else if (sb.size() == 0) begin
                $display("FAIL unexpected_write: got %02h, required no write",
                         bus.fifo_wdata);
            end else begin
                exp_b = sb.pop_front();
                if (bus.fifo_wdata !== exp_b)
                    $display("FAIL fifo_wdata: got %02h, required %02h",
                             bus.fifo_wdata, exp_b);
                else
                    pass_cnt++;
            end
        end
        if (bus.s_ready && busy) begin
            total_cnt++;
            $display("FAIL ready_in_busy: s_ready=1 busy=1, required s_ready=0");
        end
        if (drop_pulse) begin
            drop_count++;
            drop_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        @(negedge w_clk);
        while (!bus.s_ready && n < 300) begin
            @(negedge w_clk);
            n++;
            ready_waits++;
        end
        if (!bus.s_ready) begin
            total_cnt++;
            $display("FAIL send_timeout: s_ready=0, required 1");
        end
        beat_cyc = cyc;
        @(posedge w_clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge w_clk);
            n++;
        end
        total_cnt++;
        if (sb.size() != 0)
            $display("FAIL %s_drain: %0d bytes left, required 0", name, sb.size());
        else
            pass_cnt++;
        @(negedge w_clk);
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_reset();
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.fifo_full = 1'b0;
        rst_n         = 1'b0;
        @(posedge w_clk);
        @(negedge w_clk);
        total_cnt++;
        if ({bus.s_ready, bus.fifo_w_en, busy, drop_pulse} !== 4'b0000 ||
            bus.fifo_wdata !== 8'h00 || pkt_cnt !== 8'h00)
            $display("FAIL reset_outputs: rdy=%b wen=%b wd=%02h busy=%b drop=%b cnt=%0d, required all 0",
                     bus.s_ready, bus.fifo_w_en, bus.fifo_wdata, busy, drop_pulse, pkt_cnt);
        else
            pass_cnt++;
        @(posedge w_clk);
        #1;
        rst_n = 1'b1;
        @(negedge w_clk);
        total_cnt++;
        if (bus.s_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL post_reset: rdy=%b busy=%b, required rdy=1 busy=0",
                     bus.s_ready, busy);
        else
            pass_cnt++;
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] pkt [3] = '{8'h11, 8'h22, 8'h33};
        int n;
        wr_cyc.delete();
        sb.push_back(8'hA3);
        foreach (pkt[i]) sb.push_back(pkt[i]);
        foreach (pkt[i]) send_byte(pkt[i], i == 2);
        n = beat_cyc;
        drain("basic");
        total_cnt++;
        if (wr_cyc.size() != 4) begin
            $display("FAIL basic_wr_count: got %0d, required 4", wr_cyc.size());
        end else begin
            pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                total_cnt++;
                if (wr_cyc[i] != n + 1 + i)
                    $display("FAIL basic_wr_cycle%0d: got %0d, required %0d",
                             i, wr_cyc[i], n + 1 + i);
                else
                    pass_cnt++;
            end
        end
        total_cnt++;
        if (pkt_cnt !== 8'd1)
            $display("FAIL basic_pkt_cnt: got %0d, required 1", pkt_cnt);
        else
            pass_cnt++;
    endtask

    task automatic test_full_stall();
        logic [7:0] pkt [3] = '{8'h11, 8'h22, 8'h33};
        int n = 0;
        int w0;
        sb.push_back(8'hA3);
        foreach (pkt[i]) sb.push_back(pkt[i]);
        foreach (pkt[i]) send_byte(pkt[i], i == 2);
        @(negedge w_clk);
        while (!bus.fifo_w_en && n < 20) begin
            @(negedge w_clk);
            n++;
        end
        @(posedge w_clk);
        #1;
        bus.fifo_full = 1'b1;
        w0 = wen_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge w_clk);
            total_cnt++;
            if (bus.fifo_w_en !== 1'b0 || busy !== 1'b1)
                $display("FAIL stall_cycle%0d: wen=%b busy=%b, required wen=0 busy=1",
                         i, bus.fifo_w_en, busy);
            else
                pass_cnt++;
        end
        @(posedge w_clk);
        #1;
        bus.fifo_full = 1'b0;
        drain("stall");
        total_cnt++;
        if (wen_count - w0 != 3)
            $display("FAIL stall_payload_writes: got %0d, required 3", wen_count - w0);
        else
            pass_cnt++;
        total_cnt++;
        if (pkt_cnt !== 8'd2)
            $display("FAIL stall_pkt_cnt: got %0d, required 2", pkt_cnt);
        else
            pass_cnt++;
    endtask

    task automatic test_max_len();
        int low = 0;
        sb.push_back(8'hAF);
        for (int i = 1; i <= 15; i++) sb.push_back(8'(i));
        for (int i = 1; i <= 15; i++) send_byte(8'(i), i == 15);
        @(negedge w_clk);
        while (!bus.s_ready && low < 100) begin
            low++;
            @(negedge w_clk);
        end
        total_cnt++;
        if (low != 16)
            $display("FAIL max_len_ready_low: got %0d cycles, required 16", low);
        else
            pass_cnt++;
        drain("max_len");
    endtask

    task automatic test_drop();
        int w0 = wen_count;
        int d0 = drop_count;
        int last_beat;
        ready_waits = 0;
        for (int i = 0; i < 17; i++) send_byte(8'(8'h40 + i), i == 16);
        last_beat = beat_cyc;
        repeat (3) @(negedge w_clk);
        total_cnt++;
        if (wen_count != w0)
            $display("FAIL drop_writes: got %0d, required 0", wen_count - w0);
        else
            pass_cnt++;
        total_cnt++;
        if (ready_waits != 0)
            $display("FAIL drop_ready: %0d stalled cycles, required 0", ready_waits);
        else
            pass_cnt++;
        total_cnt++;
        if (drop_count - d0 != 1 || drop_cyc != last_beat + 1)
            $display("FAIL drop_pulse: count=%0d at %0d, required 1 at %0d",
                     drop_count - d0, drop_cyc, last_beat + 1);
        else
            pass_cnt++;
        @(posedge w_clk);
        #1;
        sb.push_back(8'hA1);
        sb.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        drain("after_drop");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) sb.push_back(8'hA5);
            sb.push_back(8'(8'hC0 + i));
        end
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), i == 4);
        while (n < 3 && ready_waits < 100000) begin
            @(negedge w_clk);
            if (bus.fifo_w_en) n++;
        end
        @(posedge w_clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(negedge w_clk);
        total_cnt++;
        if ({bus.s_ready, bus.fifo_w_en, busy, drop_pulse} !== 4'b0000 ||
            bus.fifo_wdata !== 8'h00)
            $display("FAIL mid_reset_outputs: rdy=%b wen=%b wd=%02h busy=%b drop=%b, required all 0",
                     bus.s_ready, bus.fifo_w_en, bus.fifo_wdata, busy, drop_pulse);
        else
            pass_cnt++;
        @(posedge w_clk);
        #1;
        rst_n = 1'b1;
        @(negedge w_clk);
        total_cnt++;
        if (pkt_cnt !== 8'd0 || bus.s_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL mid_reset_state: cnt=%0d rdy=%b busy=%b, required 0/1/0",
                     pkt_cnt, bus.s_ready, busy);
        else
            pass_cnt++;
        repeat (3) @(negedge w_clk);
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom_range(0, 255));
            sb.push_back(8'hA1);
            sb.push_back(d);
            send_byte(d, 1'b1);
            if (i == 254) begin
                drain("b2b_255");
                total_cnt++;
                if (pkt_cnt !== 8'd255)
                    $display("FAIL b2b_pkt_cnt_255: got %0d, required 255", pkt_cnt);
                else
                    pass_cnt++;
            end
        end
        drain("b2b");
        total_cnt++;
        if (pkt_cnt !== 8'd0)
            $display("FAIL b2b_pkt_cnt_wrap: got %0d, required 0", pkt_cnt);
        else
            pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_stall();
        test_max_len();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
